line_buf_ctrl: RTL and testbench
================================

// Module: line_buf_ctrl
// PURPOSE
//  Sequences three 640x12b row-buffer RAMs as a rotating 3-line window store for 3x3 convolution.
//  Accepts a raster pixel stream, steers each pixel to one buffer and advances the shared read pointer.
//  Pulses the buffers' pointer reset between rows and flags when the three 36b row outputs form a window.
//  Sits between the camera pixel stream and the edge-detect kernel.
// PARAMETERS
//  IMG_W   640  pixels per row; col counter width = $clog2(IMG_W)
//  IMG_H   480  rows per frame; row counter width = $clog2(IMG_H)
// PORTS
//  CLOCK_50    in   1   single clock, all logic posedge
//  rst_n       in   1   asynchronous, active-low reset
//  in_valid    in   1   pixel strobe from upstream
//  in_sof      in   1   start of frame, qualifies first pixel of frame (with in_valid)
//  in_ready    out  1   controller can accept; pixel accepted when in_valid && in_ready
//  row_wr_en   out  3   one-hot write enable to row buffers 0..2
//  row_rd_en   out  1   shared read-pointer advance to all three buffers
//  row_rst     out  1   sync pointer reset to all three buffers (wr_ptr=rd_ptr=0)
//  top_sel     out  2   buffer index holding top window row; mid=(top+1)%3, bot=(top+2)%3
//  win_valid   out  1   the three buffer outputs form a valid 3x3 window this cycle
//  win_col     out  10  window centre column (1..IMG_W-2)
//  win_row     out  9   window centre row (1..IMG_H-2)
//  frame_done  out  1   one-cycle pulse after last window of frame
//  sof_err     out  1   one-cycle pulse on in_sof seen mid-frame
// BEHAVIOUR
//  Reset: state=IDLE, counters=0, wr_sel=0, top_sel=0; every output 0 (in_ready included).
//  FSM: IDLE -> FILL (rows 0,1) -> RUN (rows 2..IMG_H-1) -> DONE -> IDLE; plus GAP (row end).
//  IDLE: in_ready=1; pixel without in_sof is discarded (no write); in_sof pixel = (col0,row0), enter FILL.
//  Accept (FILL/RUN): row_wr_en[wr_sel]=1 combinationally with accept; col++.
//  Window: accepted pixel in RUN with col c>=2 -> next cycle win_valid=1 and row_rd_en=1,
//  win_col=c-1, win_row=r-1. Latency 1 clk accept->window; 638 windows/row, 478 rows = 304964 per frame.
//  Row end (accept at col IMG_W-1): next cycle GAP: in_ready=0, row_rst=1 (coincident with final win_valid),
//  wr_sel=(wr_sel+1)%3; col=0, row++. In RUN only, top_sel=(top_sel+1)%3. Back to FILL/RUN after 1 cycle.
//  FILL->RUN when row reaches 2; top_sel=0 at first RUN row (buffers 0,1 hold rows 0,1; row 2 -> buf 2).
//  Frame end: accept (IMG_W-1,IMG_H-1) -> DONE: final win_valid, row_rst=1, frame_done=1, in_ready=0.
//  Next cycle IDLE: counters, wr_sel and top_sel cleared.
//  Mid-frame in_sof (FILL/RUN with in_valid): in_ready=0 combinationally (pixel not accepted).
//  Same cycle: sof_err=1; next cycle row_rst=1, counters cleared, IDLE; sof pixel then accepted as new frame.
//  in_valid low: no write, no window, counters hold; gaps anywhere in a row are legal.
//  rst_n low mid-frame: immediate return to reset values. Buffer pointers are reset by first row_rst only.
//  Integrator ties the buffer reset to (row_rst | ~rst_n).
//  Counters never exceed IMG_W-1 / IMG_H-1; wr_sel/top_sel wrap 2->0.
// STRUCTURE
//  line_buf_pkg: state encoding localparams (IDLE,FILL,RUN,GAP,DONE), default IMG_W/IMG_H.
//  line_buf_pkg also holds COL_W/ROW_W and the mod-3 increment function.
//  One sub-module: line_buf_cnt -- col/row counter pair with accept-inc, row-end wrap, and clear.
//  line_buf_cnt provides the last_col/last_row flags. FSM, select rotation and output registers stay in top.
// TESTING
//  1) Reset release, in_valid=0 -> all outputs 0 except in_ready=1 from first cycle after reset.
//  2) Full 640x480 frame, continuous valid -> 304964 win_valid; first window at win_col=1,win_row=1.
//     The first window appears 1 clk after pixel (2,2) is accepted; frame_done once, 1 clk after last pixel.
//  3) Row boundary: after col 639, in_ready=0 for exactly 1 clk with row_rst=1; wr_sel 2->0.
//     top_sel increments per RUN row, following the sequence 0,1,2,0...
//  4) Pixels without in_sof while IDLE -> no row_wr_en; sof arrives -> row_wr_en=3'b001 on that accept.
//  5) in_sof at (100,50) -> sof_err pulse, row_rst next clk, restart; new frame windows begin at row 1.
//  6) Random in_valid gaps (50% duty) -> same window count and order as scenario 2.
//     win_col/win_row checked against a reference model.

Source files
------------

// File: rtl/line_buf_pkg.sv
// Shared types, default geometry and helpers for the 3-line window controller.
package line_buf_pkg;

  // Default frame geometry and the port widths derived from it.
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int COL_W     = $clog2(IMG_W_DEF);
  localparam int ROW_W     = $clog2(IMG_H_DEF);

  // Controller states: GAP is the one-cycle pause between rows.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_RUN  = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Increment a buffer index modulo 3 (0 -> 1 -> 2 -> 0).
  function automatic logic [1:0] mod3_inc(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

endpackage

// File: rtl/line_buf_cnt.sv
// Column/row position counter for the pixel stream, with end-of-row and
// end-of-frame flags. Wraps to (0,0) after the last pixel of a frame.
module line_buf_cnt
  import line_buf_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_inc,
  input  logic                     i_clr,
  output logic [$clog2(IMG_W)-1:0] o_col,
  output logic [$clog2(IMG_H)-1:0] o_row,
  output logic                     o_last_col,
  output logic                     o_last_row
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  assign o_last_col = (r_col == CW'(IMG_W - 1));
  assign o_last_row = (r_row == RW'(IMG_H - 1));
  assign o_col      = r_col;
  assign o_row      = r_row;

  // Advance on each written pixel; clear has priority over increment.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clr) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_inc) begin
      if (o_last_col) begin
        r_col <= '0;
        r_row <= o_last_row ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/line_buf_ctrl.sv
// Rotating 3-line buffer sequencer: steers pixels into three row RAMs,
// advances their shared read pointer and flags valid 3x3 windows.
module line_buf_ctrl
  import line_buf_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic             CLOCK_50,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  output logic             in_ready,
  output logic [2:0]       row_wr_en,
  output logic             row_rd_en,
  output logic             row_rst,
  output logic [1:0]       top_sel,
  output logic             win_valid,
  output logic [COL_W-1:0] win_col,
  output logic [ROW_W-1:0] win_row,
  output logic             frame_done,
  output logic             sof_err
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  state_t           r_state, w_state_next;
  logic [1:0]       r_wr_sel, w_wr_sel_next;
  logic [1:0]       r_top_sel, w_top_sel_next;
  logic             r_win_valid, w_win_valid_next;
  logic [COL_W-1:0] r_win_col, w_win_col_next;
  logic [ROW_W-1:0] r_win_row, w_win_row_next;
  logic             r_row_rst, w_row_rst_next;
  logic             r_frame_done, w_frame_done_next;
  logic             r_alive;

  logic             w_in_ready, w_abort, w_wr, w_cnt_clr, w_in_frame;
  logic [CW-1:0]    w_col;
  logic [RW-1:0]    w_row;
  logic             w_last_col, w_last_row;

  assign w_in_frame = (r_state == ST_FILL) || (r_state == ST_RUN);
  // A pixel is written when accepted inside a frame, or when it is the SOF pixel in IDLE.
  assign w_wr       = in_valid && w_in_ready && (w_in_frame || ((r_state == ST_IDLE) && in_sof));
  assign w_cnt_clr  = w_abort || (r_state == ST_DONE);

  line_buf_cnt #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_cnt (
    .i_clk      (CLOCK_50),
    .i_rst_n    (rst_n),
    .i_inc      (w_wr),
    .i_clr      (w_cnt_clr),
    .o_col      (w_col),
    .o_row      (w_row),
    .o_last_col (w_last_col),
    .o_last_row (w_last_row)
  );

  // Next-state, select rotation, registered-output next values and handshake.
  always_comb begin
    w_state_next      = r_state;
    w_wr_sel_next     = r_wr_sel;
    w_top_sel_next    = r_top_sel;
    w_win_valid_next  = 1'b0;
    w_win_col_next    = r_win_col;
    w_win_row_next    = r_win_row;
    w_row_rst_next    = 1'b0;
    w_frame_done_next = 1'b0;
    w_in_ready        = 1'b0;
    w_abort           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // r_alive keeps in_ready low while reset is held.
        w_in_ready = r_alive;
        if (r_alive && in_valid && in_sof) w_state_next = ST_FILL;
      end
      ST_FILL, ST_RUN: begin
        if (in_valid && in_sof) begin
          // SOF mid-frame: refuse it, flush pointers and let IDLE take it as a new frame.
          w_abort        = 1'b1;
          w_state_next   = ST_IDLE;
          w_wr_sel_next  = 2'd0;
          w_top_sel_next = 2'd0;
          w_row_rst_next = 1'b1;
        end else begin
          w_in_ready = 1'b1;
          if (in_valid && (r_state == ST_RUN) && (w_col >= CW'(2))) begin
            w_win_valid_next = 1'b1;
            w_win_col_next   = COL_W'(w_col) - COL_W'(1);
            w_win_row_next   = ROW_W'(w_row) - ROW_W'(1);
          end
          if (in_valid && w_last_col) begin
            w_row_rst_next = 1'b1;
            if ((r_state == ST_RUN) && w_last_row) begin
              w_state_next      = ST_DONE;
              w_frame_done_next = 1'b1;
            end else begin
              w_state_next = ST_GAP;
            end
          end
        end
      end
      ST_GAP: begin
        // Row counter already points at the next row; rotate once the final window is out.
        w_wr_sel_next = mod3_inc(r_wr_sel);
        if (w_row >= RW'(3)) w_top_sel_next = mod3_inc(r_top_sel);
        w_state_next = (w_row >= RW'(2)) ? ST_RUN : ST_FILL;
      end
      ST_DONE: begin
        w_state_next   = ST_IDLE;
        w_wr_sel_next  = 2'd0;
        w_top_sel_next = 2'd0;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // State, select and output registers.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_wr_sel     <= 2'd0;
      r_top_sel    <= 2'd0;
      r_win_valid  <= 1'b0;
      r_win_col    <= '0;
      r_win_row    <= '0;
      r_row_rst    <= 1'b0;
      r_frame_done <= 1'b0;
      r_alive      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_wr_sel     <= w_wr_sel_next;
      r_top_sel    <= w_top_sel_next;
      r_win_valid  <= w_win_valid_next;
      r_win_col    <= w_win_col_next;
      r_win_row    <= w_win_row_next;
      r_row_rst    <= w_row_rst_next;
      r_frame_done <= w_frame_done_next;
      r_alive      <= 1'b1;
    end
  end

  assign in_ready   = w_in_ready;
  assign row_wr_en  = w_wr ? (3'b001 << r_wr_sel) : 3'b000;
  assign row_rd_en  = r_win_valid;
  assign row_rst    = r_row_rst;
  assign top_sel    = r_top_sel;
  assign win_valid  = r_win_valid;
  assign win_col    = r_win_col;
  assign win_row    = r_win_row;
  assign frame_done = r_frame_done;
  assign sof_err    = w_abort;

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Self-checking bench for line_buf_ctrl on a reduced 16x8 frame.
module tb_line_buf_ctrl;
  import line_buf_pkg::*;

  localparam int W    = 16;
  localparam int H    = 8;
  localparam int NWIN = (W - 2) * (H - 2);

  logic             CLOCK_50 = 1'b0;
  logic             rst_n, in_valid, in_sof;
  logic             in_ready, row_rd_en, row_rst, win_valid, frame_done, sof_err;
  logic [2:0]       row_wr_en;
  logic [1:0]       top_sel;
  logic [COL_W-1:0] win_col;
  logic [ROW_W-1:0] win_row;

  always #5 CLOCK_50 = ~CLOCK_50;

  line_buf_ctrl #(.IMG_W(W), .IMG_H(H)) dut (
    .CLOCK_50   (CLOCK_50),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_ready   (in_ready),
    .row_wr_en  (row_wr_en),
    .row_rd_en  (row_rd_en),
    .row_rst    (row_rst),
    .top_sel    (top_sel),
    .win_valid  (win_valid),
    .win_col    (win_col),
    .win_row    (win_row),
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

  typedef struct {
    int col;
    int row;
    int top;
    bit last;
  } win_t;

  typedef struct packed {
    logic       v;
    logic       s;
    logic       rdy;
    logic [2:0] wr;
    logic       err;
    logic       rr;
  } vec_t;

  win_t sb[$];
  vec_t tbl [0:9];
  int   checks = 0, errors = 0, win_cnt = 0, done_cnt = 0;

  task automatic chk(input string name, input bit ok, input string msg);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, msg);
    end
  endtask

  // Window monitor: every win_valid pops the scoreboard.
  always @(negedge CLOCK_50) begin
    win_t e;
    if (rst_n) begin
      if (win_valid) begin
        win_cnt++;
        if (sb.size() == 0) begin
          chk("win_extra", 1'b0, $sformatf("got col=%0d row=%0d, required none", win_col, win_row));
        end else begin
          e = sb.pop_front();
          chk("window", (win_col == e.col) && (win_row == e.row) && (top_sel == e.top) &&
              row_rd_en && (frame_done == e.last),
              $sformatf("got col=%0d row=%0d top=%0d rd=%b done=%b, required col=%0d row=%0d top=%0d rd=1 done=%b",
                        win_col, win_row, top_sel, row_rd_en, frame_done, e.col, e.row, e.top, e.last));
        end
      end else if (row_rd_en || frame_done) begin
        chk("stray", 1'b0, $sformatf("got rd=%b done=%b without win_valid, required 0", row_rd_en, frame_done));
      end
      if (frame_done) done_cnt++;
    end
  end

  task automatic idle_cycle();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    @(negedge CLOCK_50);
  endtask

  // Offer one pixel, wait (bounded) for acceptance, check the write strobe, book the window.
  task automatic send(input bit sof, input int x, input int y);
    int         n;
    win_t       e;
    logic [2:0] exp_wr;
    n = 0;
    in_valid = 1'b1;
    in_sof   = sof;
    #1;
    while (!in_ready && n < 10) begin
      @(negedge CLOCK_50);
      #1;
      n++;
    end
    if (!in_ready) begin
      chk("stall", 1'b0, $sformatf("x=%0d y=%0d got in_ready=0 for %0d clk, required 1", x, y, n));
    end else begin
      exp_wr = 3'b001 << (y % 3);
      chk("wr_en", row_wr_en == exp_wr,
          $sformatf("x=%0d y=%0d got %b required %b", x, y, row_wr_en, exp_wr));
      if (x >= 2 && y >= 2) begin
        e.col  = x - 1;
        e.row  = y - 1;
        e.top  = (y - 2) % 3;
        e.last = (x == W - 1) && (y == H - 1);
        sb.push_back(e);
      end
      @(negedge CLOCK_50);
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  // After the last pixel of a row: one stall cycle with row_rst, then ready again.
  task automatic check_boundary(input int y);
    #1;
    chk("row_end_gap", !in_ready && row_rst,
        $sformatf("y=%0d got ready=%b row_rst=%b, required 0/1", y, in_ready, row_rst));
    @(negedge CLOCK_50);
    #1;
    chk("row_end_resume", in_ready && !row_rst,
        $sformatf("y=%0d got ready=%b row_rst=%b, required 1/0", y, in_ready, row_rst));
  endtask

  // Mid-frame SOF: refused with sof_err, then accepted as (0,0) of a new frame.
  task automatic do_abort();
    in_valid = 1'b1;
    in_sof   = 1'b1;
    #1;
    chk("sof_err", !in_ready && sof_err && (row_wr_en == 3'b000),
        $sformatf("got ready=%b err=%b wr=%b, required 0/1/000", in_ready, sof_err, row_wr_en));
    @(negedge CLOCK_50);
    #1;
    chk("sof_restart", in_ready && row_rst && !sof_err && (row_wr_en == 3'b001),
        $sformatf("got ready=%b row_rst=%b err=%b wr=%b, required 1/1/0/001", in_ready, row_rst, sof_err, row_wr_en));
    @(negedge CLOCK_50);
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic run_frame(input bit gaps, input int ax, input int ay);
    int x, y;
    bit first, aborted;
    x = 0; y = 0; first = 1'b1; aborted = 1'b0;
    while (y < H) begin
      if (gaps && ($urandom_range(0, 1) == 1)) idle_cycle();
      if (!aborted && x == ax && y == ay) begin
        do_abort();
        aborted = 1'b1;
        x = 1;
        y = 0;
      end else begin
        send(first, x, y);
        first = 1'b0;
        if (x == W - 1) begin
          check_boundary(y);
          x = 0;
          y++;
        end else begin
          x++;
        end
      end
    end
  endtask

  task automatic end_frame(input string name, input int exp_win);
    repeat (4) @(negedge CLOCK_50);
    chk({name, "_wins"}, win_cnt == exp_win, $sformatf("got %0d windows, required %0d", win_cnt, exp_win));
    chk({name, "_done"}, done_cnt == 1, $sformatf("got %0d frame_done, required 1", done_cnt));
    chk({name, "_sb"}, sb.size() == 0, $sformatf("got %0d pending windows, required 0", sb.size()));
    win_cnt  = 0;
    done_cnt = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // {valid, sof, ready, wr_en, sof_err, row_rst} from IDLE after reset.
    tbl[0] = {1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0};
    tbl[1] = {1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0};
    tbl[2] = {1'b1, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0};
    tbl[3] = {1'b0, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0};
    tbl[4] = {1'b1, 1'b1, 1'b1, 3'b001, 1'b0, 1'b0};
    tbl[5] = {1'b1, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0};
    tbl[6] = {1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0};
    tbl[7] = {1'b1, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0};
    tbl[8] = {1'b1, 1'b1, 1'b1, 3'b001, 1'b0, 1'b1};
    tbl[9] = {1'b0, 1'b0, 1'b1, 3'b000, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    #1;
    chk("reset_outputs", {in_ready, row_wr_en, row_rd_en, row_rst, top_sel, win_valid, win_col, win_row, frame_done, sof_err} == '0,
        $sformatf("got ready=%b wr=%b rd=%b rst=%b top=%0d wv=%b", in_ready, row_wr_en, row_rd_en, row_rst, top_sel, win_valid));
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLOCK_50);
      #1;
      chk("post_reset", in_ready && ({row_wr_en, row_rd_en, row_rst, top_sel, win_valid, frame_done, sof_err} == '0),
          $sformatf("cyc=%0d got ready=%b wr=%b rst=%b wv=%b err=%b, required ready only", i, in_ready, row_wr_en, row_rst, win_valid, sof_err));
    end

    for (int i = 0; i < 10; i++) begin
      @(negedge CLOCK_50);
      in_valid = tbl[i].v;
      in_sof   = tbl[i].s;
      #1;
      chk("idle_vec", (in_ready == tbl[i].rdy) && (row_wr_en == tbl[i].wr) && (sof_err == tbl[i].err) && (row_rst == tbl[i].rr),
          $sformatf("vec=%0d got ready=%b wr=%b err=%b rst=%b, required %b/%b/%b/%b",
                    i, in_ready, row_wr_en, sof_err, row_rst, tbl[i].rdy, tbl[i].wr, tbl[i].err, tbl[i].rr));
    end

    @(negedge CLOCK_50);
    in_valid = 1'b0; in_sof = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midframe_reset", {in_ready, row_wr_en, row_rd_en, row_rst, top_sel, win_valid, frame_done, sof_err} == '0,
        $sformatf("got ready=%b wr=%b rst=%b top=%0d, required all 0", in_ready, row_wr_en, row_rst, top_sel));
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    @(negedge CLOCK_50);
    win_cnt = 0; done_cnt = 0;

    run_frame(1'b0, -1, -1);
    end_frame("cont", NWIN);

    run_frame(1'b1, -1, -1);
    end_frame("gaps", NWIN);

    run_frame(1'b0, 5, 3);
    end_frame("abort", (W - 2) * (3 - 2) + (5 - 2) + NWIN);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
